cpu_datapath_units: RTL and testbench
=====================================

CPU_DATAPATH_UNITS -- requirements
Module: cpu_datapath_units

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; clock port clock_in, reset port reset_in.
REQ-002 Parameter DATA_WIDTH, default 8, SHALL set the width of every data word.
REQ-003 Parameter RF_DEPTH, default 256, SHALL set the register-file entry count, addressed by 8 bits.
REQ-004 Parameter MAT_DIM, default 4, SHALL set the tensor-core matrix dimension (square).
REQ-005 clock_in  input  1  SHALL be the rising-edge clock for all state.
REQ-006 reset_in  input  1  SHALL be the synchronous active-high reset.
REQ-007 alu_enable_in  input  1  SHALL, when high, allow the ALU output register to update.
REQ-008 alu_opcode_in  input  8  SHALL select the ALU operation.
REQ-009 alu_input1 / alu_input2  input  8 each  SHALL be the ALU operands A and B.
REQ-010 alu_output  output  8  SHALL be the registered ALU result.
REQ-011 rf_write_enable_in  input  1  SHALL be the register-file write strobe.
REQ-012 rf_write_register_address_in  input  8  SHALL be the write address.
REQ-013 rf_write_data_in  input  8  SHALL be the write data.
REQ-014 rf_read_register_address1_in / rf_read_register_address2_in  input  8 each  SHALL be the two read addresses.
REQ-015 rf_read_data1_out / rf_read_data2_out  output  8 each  SHALL be the two read ports.
REQ-016 tensor_core_input1 / tensor_core_input2  input  [4][4] x 8  SHALL be matrices A and B, indexed [row][col].
REQ-017 tensor_core_output  output  [4][4] x 8  SHALL be the product matrix C, indexed [row][col].

Function
REQ-018 The ALU result SHALL be registered: on a rising edge with reset_in low and alu_enable_in high, alu_output takes the selected result; alu_output holds when alu_enable_in is low.
REQ-019 ALU latency SHALL be exactly one clock from operand/opcode sampling to alu_output.
REQ-020 The ALU opcode map SHALL be: 0 ADD, 1 SUB (A-B), 2 AND, 3 OR, 4 XOR; any other opcode SHALL produce 0.
REQ-021 ALU arithmetic SHALL be unsigned, modulo 256, with no carry or flag outputs; e.g. 200+100=44 and 3-5=254.
REQ-022 Register-file reads SHALL be combinational, and both ports SHALL be independent; the same address on both ports is allowed.
REQ-023 A register-file write SHALL occur on the rising edge when rf_write_enable_in is high and reset_in is low; every address 0-255 is writable, with no hardwired-zero register.
REQ-024 Read-during-write to the same address SHALL return the old value until the edge, and the new value after the edge; there is no bypass.
REQ-025 The tensor core SHALL be purely combinational: C[i][j] = sum over k=0..3 of A[i][k]*B[k][j].
REQ-026 Tensor-core operands SHALL be unsigned, and products and sum SHALL be truncated to the low 8 bits (modulo 256); there is no saturation.
REQ-027 The tensor core SHALL ignore clock_in and reset_in, and the output SHALL settle within the same cycle as an input change.

Reset
REQ-028 While reset_in is high at a rising edge, alu_output SHALL become 0, regardless of alu_enable_in.
REQ-029 While reset_in is high at a rising edge, all 256 register-file entries SHALL become 0, and a concurrent write SHALL be discarded.
REQ-030 Reset asserted mid-operation SHALL take effect at the next edge, and the first post-reset edge SHALL operate normally.
REQ-031 tensor_core_output SHALL be unaffected by reset and SHALL always reflect the current inputs.

Verification
REQ-032 ALU: enable=1, opcode 0, A=200, B=100 -> alu_output=44 one cycle later; opcode 1, A=3, B=5 -> 254; opcode 7 -> 0.
REQ-033 ALU hold/reset: set alu_output=9, then enable=0 with new operands -> alu_output stays 9; assert reset_in for one edge -> alu_output=0.
REQ-034 Register file: write 0xAB to address 255 and 0x12 to address 0 -> read1(255)=0xAB and read2(0)=0x12 in the same cycle; read1=read2=255 -> both 0xAB.
REQ-035 Read-during-write: address 5 holds 1; write 2 to address 5 with read1 on address 5 -> 1 before the edge, 2 after it.
REQ-036 Tensor core: A=identity, B[i][j]=4i+j -> C=B; A and B all 16 -> every C entry = 4*256 mod 256 = 0; A and B all 3 -> every C entry = 36.
REQ-037 Reset clears the register file: after the writes above, one reset edge -> reads of addresses 0 and 255 return 0.

Source files
------------

// File: rtl/cpu_datapath_units.sv
`default_nettype none
// ============================================================================
// Module      : cpu_datapath_units
// Description : Three independent CPU datapath units sharing one clock:
//               - registered 8-bit ALU (ADD/SUB/AND/OR/XOR, one-cycle latency,
//                 hold when not enabled)
//               - RF_DEPTH x DATA_WIDTH register file, one write port and two
//                 independent combinational read ports, no write bypass
//               - purely combinational MAT_DIM x MAT_DIM tensor core
//                 computing C = A * B modulo 2**DATA_WIDTH
// Ports       : clock_in / reset_in              clock, sync active-high reset
//               alu_enable_in, alu_opcode_in,
//               alu_input1, alu_input2           ALU controls and operands
//               alu_output                       registered ALU result
//               rf_write_*                       register-file write port
//               rf_read_register_address{1,2}_in read addresses
//               rf_read_data{1,2}_out            combinational read data
//               tensor_core_input{1,2}           matrices A, B [row][col]
//               tensor_core_output               product matrix C [row][col]
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_datapath_units #(
    parameter int DATA_WIDTH = 8,
    parameter int RF_DEPTH   = 256,
    parameter int MAT_DIM    = 4
) (
    input  logic                                           clock_in,
    input  logic                                           reset_in,
    // ALU
    input  logic                                           alu_enable_in,
    input  logic [7:0]                                     alu_opcode_in,
    input  logic [DATA_WIDTH-1:0]                          alu_input1,
    input  logic [DATA_WIDTH-1:0]                          alu_input2,
    output logic [DATA_WIDTH-1:0]                          alu_output,
    // Register file
    input  logic                                           rf_write_enable_in,
    input  logic [7:0]                                     rf_write_register_address_in,
    input  logic [DATA_WIDTH-1:0]                          rf_write_data_in,
    input  logic [7:0]                                     rf_read_register_address1_in,
    input  logic [7:0]                                     rf_read_register_address2_in,
    output logic [DATA_WIDTH-1:0]                          rf_read_data1_out,
    output logic [DATA_WIDTH-1:0]                          rf_read_data2_out,
    // Tensor core
    input  logic [MAT_DIM-1:0][MAT_DIM-1:0][DATA_WIDTH-1:0] tensor_core_input1,
    input  logic [MAT_DIM-1:0][MAT_DIM-1:0][DATA_WIDTH-1:0] tensor_core_input2,
    output logic [MAT_DIM-1:0][MAT_DIM-1:0][DATA_WIDTH-1:0] tensor_core_output
);

    localparam logic [7:0] c_OP_ADD = 8'd0;
    localparam logic [7:0] c_OP_SUB = 8'd1;
    localparam logic [7:0] c_OP_AND = 8'd2;
    localparam logic [7:0] c_OP_OR  = 8'd3;
    localparam logic [7:0] c_OP_XOR = 8'd4;

    // ------------------------------------------------------------------------
    // ALU
    // ------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] w_alu_result;
    logic [DATA_WIDTH-1:0] r_alu_output;

    // Arithmetic wraps naturally at DATA_WIDTH bits; no carry is kept.
    always_comb begin
        w_alu_result = '0;
        case (alu_opcode_in)
            c_OP_ADD: w_alu_result = alu_input1 + alu_input2;
            c_OP_SUB: w_alu_result = alu_input1 - alu_input2;
            c_OP_AND: w_alu_result = alu_input1 & alu_input2;
            c_OP_OR:  w_alu_result = alu_input1 | alu_input2;
            c_OP_XOR: w_alu_result = alu_input1 ^ alu_input2;
            default:  w_alu_result = '0;
        endcase
    end

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            r_alu_output <= '0;
        end else if (alu_enable_in) begin
            r_alu_output <= w_alu_result;
        end
    end

    assign alu_output = r_alu_output;

    // ------------------------------------------------------------------------
    // Register file: every entry is writable (no hardwired zero). Reads see
    // the stored array directly, so a same-address write becomes visible only
    // after the edge.
    // ------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] r_rf [RF_DEPTH];

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            // Reset wins over a concurrent write.
            for (int i = 0; i < RF_DEPTH; i++) begin
                r_rf[i] <= '0;
            end
        end else if (rf_write_enable_in) begin
            r_rf[rf_write_register_address_in] <= rf_write_data_in;
        end
    end

    assign rf_read_data1_out = r_rf[rf_read_register_address1_in];
    assign rf_read_data2_out = r_rf[rf_read_register_address2_in];

    // ------------------------------------------------------------------------
    // Tensor core: one multiply-accumulate tree per output element. The
    // accumulator is DATA_WIDTH wide so products and sums wrap modulo
    // 2**DATA_WIDTH without saturation.
    // ------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < MAT_DIM; gi++) begin : g_row
            for (genvar gj = 0; gj < MAT_DIM; gj++) begin : g_col
                logic [DATA_WIDTH-1:0] w_acc;

                always_comb begin
                    w_acc = '0;
                    for (int k = 0; k < MAT_DIM; k++) begin
                        w_acc = w_acc + tensor_core_input1[gi][k] * tensor_core_input2[k][gj];
                    end
                end

                assign tensor_core_output[gi][gj] = w_acc;
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_cpu_datapath_units.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_datapath_units
// Description : Scoreboard bench for cpu_datapath_units. The stimulus task
//               drives one cycle at the falling edge and pushes expectations
//               from an arithmetic reference model; a monitor pops and
//               compares before the next rising edge (combinational reads and
//               tensor output) and just after it (ALU and post-write reads).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_datapath_units;

    typedef logic [3:0][3:0][7:0] mat_t;
    typedef struct {
        logic [7:0] rd1;
        logic [7:0] rd2;
        mat_t       c;
    } pre_t;
    typedef struct {
        logic [7:0] alu;
        logic [7:0] rd1;
        logic [7:0] rd2;
    } post_t;

    logic       clk = 1'b0;
    logic       reset_in;
    logic       alu_enable_in;
    logic [7:0] alu_opcode_in, alu_input1, alu_input2, alu_output;
    logic       rf_write_enable_in;
    logic [7:0] rf_write_register_address_in, rf_write_data_in;
    logic [7:0] rf_read_register_address1_in, rf_read_register_address2_in;
    logic [7:0] rf_read_data1_out, rf_read_data2_out;
    mat_t       tensor_core_input1, tensor_core_input2, tensor_core_output;

    always #5 clk = ~clk;

    cpu_datapath_units #(
        .DATA_WIDTH(8),
        .RF_DEPTH  (256),
        .MAT_DIM   (4)
    ) dut (
        .clock_in                    (clk),
        .reset_in                    (reset_in),
        .alu_enable_in               (alu_enable_in),
        .alu_opcode_in               (alu_opcode_in),
        .alu_input1                  (alu_input1),
        .alu_input2                  (alu_input2),
        .alu_output                  (alu_output),
        .rf_write_enable_in          (rf_write_enable_in),
        .rf_write_register_address_in(rf_write_register_address_in),
        .rf_write_data_in            (rf_write_data_in),
        .rf_read_register_address1_in(rf_read_register_address1_in),
        .rf_read_register_address2_in(rf_read_register_address2_in),
        .rf_read_data1_out           (rf_read_data1_out),
        .rf_read_data2_out           (rf_read_data2_out),
        .tensor_core_input1          (tensor_core_input1),
        .tensor_core_input2          (tensor_core_input2),
        .tensor_core_output          (tensor_core_output)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [7:0] m_mem [256];
    logic [7:0] m_alu;
    bit         m_known = 1'b0;

    pre_t  q_pre[$];
    post_t q_post[$];

    function automatic logic [7:0] alu_ref(int op, int a, int b);
        case (op)
            0:       return 8'((a + b) % 256);
            1:       return 8'((a - b + 256) % 256);
            2:       return 8'(a & b);
            3:       return 8'(a | b);
            4:       return 8'(a ^ b);
            default: return 8'd0;
        endcase
    endfunction

    function automatic mat_t mat_ref(mat_t a, mat_t b);
        mat_t r;
        int   s;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                s = 0;
                for (int k = 0; k < 4; k++) s += int'(a[i][k]) * int'(b[k][j]);
                r[i][j] = 8'(s % 256);
            end
        end
        return r;
    endfunction

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic checkm(input string name, input mat_t act, input mat_t exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus plus the model's view of it.
    task automatic do_cycle(input bit rst, input bit en, input logic [7:0] op,
                            input logic [7:0] a, input logic [7:0] b,
                            input bit we, input logic [7:0] wa, input logic [7:0] wd,
                            input logic [7:0] ra1, input logic [7:0] ra2,
                            input mat_t ma, input mat_t mb);
        pre_t  p;
        post_t q;
        @(negedge clk);
        reset_in                     = rst;
        alu_enable_in                = en;
        alu_opcode_in                = op;
        alu_input1                   = a;
        alu_input2                   = b;
        rf_write_enable_in           = we;
        rf_write_register_address_in = wa;
        rf_write_data_in             = wd;
        rf_read_register_address1_in = ra1;
        rf_read_register_address2_in = ra2;
        tensor_core_input1           = ma;
        tensor_core_input2           = mb;
        if (m_known) begin
            p.rd1 = m_mem[ra1];
            p.rd2 = m_mem[ra2];
            p.c   = mat_ref(ma, mb);
            q_pre.push_back(p);
        end
        if (rst) begin
            m_alu = 8'd0;
            for (int i = 0; i < 256; i++) m_mem[i] = 8'd0;
            m_known = 1'b1;
        end else begin
            if (en) m_alu = alu_ref(int'(op), int'(a), int'(b));
            if (we) m_mem[wa] = wd;
        end
        if (m_known) begin
            q.alu = m_alu;
            q.rd1 = m_mem[ra1];
            q.rd2 = m_mem[ra2];
            q_post.push_back(q);
        end
    endtask

    // Monitor
    initial begin
        fork
            forever begin : mon_pre
                pre_t p;
                @(negedge clk);
                #2;
                if (q_pre.size() > 0) begin
                    p = q_pre.pop_front();
                    check8("rd1_before_edge", rf_read_data1_out, p.rd1);
                    check8("rd2_before_edge", rf_read_data2_out, p.rd2);
                    checkm("tensor_c", tensor_core_output, p.c);
                end
            end
            forever begin : mon_post
                post_t q;
                @(posedge clk);
                #1;
                if (q_post.size() > 0) begin
                    q = q_post.pop_front();
                    check8("alu_output", alu_output, q.alu);
                    check8("rd1_after_edge", rf_read_data1_out, q.rd1);
                    check8("rd2_after_edge", rf_read_data2_out, q.rd2);
                end
            end
        join
    end

    // Stimulus
    mat_t m_id, m_seq, m_16, m_3, m_z, ra, rb;

    initial begin
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                m_id[i][j]  = (i == j) ? 8'd1 : 8'd0;
                m_seq[i][j] = 8'(4 * i + j);
                m_16[i][j]  = 8'd16;
                m_3[i][j]   = 8'd3;
                m_z[i][j]   = 8'd0;
            end
        end

        // Reset (with a write that must be discarded)
        do_cycle(1, 1, 0, 1, 1, 1, 8'd9, 8'd99, 8'd9, 8'd0, m_z, m_z);
        do_cycle(1, 0, 0, 0, 0, 0, 8'd0, 8'd0, 8'd9, 8'd255, m_z, m_z);

        // ALU arithmetic and out-of-range opcode
        do_cycle(0, 1, 8'd0, 8'd200, 8'd100, 0, 0, 0, 0, 0, m_id, m_seq);
        do_cycle(0, 1, 8'd1, 8'd3, 8'd5, 0, 0, 0, 0, 0, m_16, m_16);
        do_cycle(0, 1, 8'd7, 8'd3, 8'd5, 0, 0, 0, 0, 0, m_3, m_3);

        // ALU hold and reset
        do_cycle(0, 1, 8'd0, 8'd4, 8'd5, 0, 0, 0, 0, 0, m_seq, m_id);
        do_cycle(0, 0, 8'd2, 8'd77, 8'd88, 0, 0, 0, 0, 0, m_seq, m_seq);
        do_cycle(1, 1, 8'd0, 8'd1, 8'd1, 0, 0, 0, 0, 0, m_seq, m_seq);

        // Register file: extreme addresses, shared read address
        do_cycle(0, 0, 0, 0, 0, 1, 8'd255, 8'hAB, 8'd255, 8'd0, m_z, m_z);
        do_cycle(0, 0, 0, 0, 0, 1, 8'd0, 8'h12, 8'd255, 8'd0, m_z, m_z);
        do_cycle(0, 0, 0, 0, 0, 0, 8'd0, 8'd0, 8'd255, 8'd0, m_z, m_z);
        do_cycle(0, 0, 0, 0, 0, 0, 8'd0, 8'd0, 8'd255, 8'd255, m_z, m_z);

        // Read-during-write: old value before the edge, new one after
        do_cycle(0, 0, 0, 0, 0, 1, 8'd5, 8'd1, 8'd5, 8'd5, m_z, m_z);
        do_cycle(0, 0, 0, 0, 0, 1, 8'd5, 8'd2, 8'd5, 8'd255, m_z, m_z);

        // Reset clears the file and discards a concurrent write
        do_cycle(1, 0, 0, 0, 0, 1, 8'd0, 8'h77, 8'd0, 8'd255, m_id, m_seq);
        do_cycle(0, 0, 0, 0, 0, 0, 8'd0, 8'd0, 8'd0, 8'd255, m_id, m_seq);

        // Randomized traffic; addresses favour a small window to force hits
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < 4; i++) begin
                for (int j = 0; j < 4; j++) begin
                    ra[i][j] = 8'($urandom);
                    rb[i][j] = 8'($urandom);
                end
            end
            do_cycle(($urandom_range(0, 29) == 0),
                     ($urandom_range(0, 3) != 0),
                     ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 6)),
                     8'($urandom), 8'($urandom),
                     ($urandom_range(0, 1) == 1),
                     ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 7)) : 8'($urandom),
                     8'($urandom),
                     ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 7)) : 8'($urandom),
                     ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 7)) : 8'($urandom),
                     ra, rb);
        end

        // Drain the scoreboard
        @(negedge clk);
        @(negedge clk);
        #5;
        n_checks++;
        if (q_pre.size() != 0 || q_post.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain actual=%0d/%0d expected=0/0", q_pre.size(), q_post.size());
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
